pwl_generator: RTL and testbench

PWL_GENERATOR -- requirements
Module: pwl_generator

---
 rtl/pwl_generator_if.sv | 12 +
 rtl/pwl_generator.sv | 189 ++++++++++++++++++
 tb/tb_pwl_generator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwl_generator_if.sv
// AXI-stream style handshake bundle carrying the DMA segment words into the PWL generator.
interface Axis_IF #(
    parameter int DATA_WIDTH = 48
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  last;
    logic                  ready;

    modport stream_in  (input data, input valid, input last, output ready);
    modport stream_out (output data, output valid, output last, input ready);
endinterface

// File: rtl/pwl_generator.sv
// Expands sparse {value, slope, dur} segments into dense sample batches, then loops them out to the DAC.
// Batch store is read with 1-cycle latency; playback holds its position while dac0_rdy is low.
module pwl_generator #(
    parameter int DMA_DATA_WIDTH    = 48,
    parameter int SAMPLE_WIDTH      = 16,
    parameter int BATCH_SIZE        = 16,
    parameter int SPARSE_BRAM_DEPTH = 600,
    parameter int DENSE_BRAM_DEPTH  = 600
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               halt,
    input  logic                               run,
    output logic                               rdy_to_run,
    input  logic                               dac0_rdy,
    output logic [BATCH_SIZE*SAMPLE_WIDTH-1:0] batch_out,
    output logic                               valid_batch_out,
    Axis_IF.stream_in                          dma
);
    localparam int LINE_W = BATCH_SIZE * SAMPLE_WIDTH;
    localparam int SA_W   = (SPARSE_BRAM_DEPTH > 1) ? $clog2(SPARSE_BRAM_DEPTH) : 1;
    localparam int SC_W   = $clog2(SPARSE_BRAM_DEPTH + 1);
    localparam int DA_W   = (DENSE_BRAM_DEPTH > 1) ? $clog2(DENSE_BRAM_DEPTH) : 1;
    localparam int DC_W   = $clog2(DENSE_BRAM_DEPTH + 1);
    localparam int FILL_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, READY, RUN} state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [46:0]               r_sparse [SPARSE_BRAM_DEPTH];
    logic [LINE_W-1:0]         r_dense  [DENSE_BRAM_DEPTH];

    logic [SC_W-1:0]           r_wr_cnt;
    logic [SC_W-1:0]           r_seg_idx;
    logic [14:0]               r_k;
    logic [SAMPLE_WIDTH-1:0]   r_acc;
    logic [LINE_W-1:0]         r_line;
    logic [FILL_W-1:0]         r_fill;
    logic [DC_W-1:0]           r_batch_cnt;
    logic [DC_W-1:0]           r_num_batches;
    logic [DA_W-1:0]           r_rd_addr;
    logic [LINE_W-1:0]         r_batch_out;
    logic                      r_loaded;

    logic [DMA_DATA_WIDTH-1:0] w_word;
    logic                      w_unused_bits;
    logic                      w_accept;
    logic [SA_W-1:0]           w_wr_addr;
    logic                      w_wr_en;
    logic [46:0]               w_seg;
    logic [SAMPLE_WIDTH-1:0]   w_value;
    logic [SAMPLE_WIDTH-1:0]   w_slope;
    logic [14:0]               w_dur;
    logic [SAMPLE_WIDTH-1:0]   w_sample;
    logic [LINE_W-1:0]         w_line_ins;
    logic [LINE_W-1:0]         w_line_pad;
    logic                      w_finish;
    logic                      w_pad;
    logic [DC_W-1:0]           w_final_batches;
    logic                      w_gen;
    logic                      w_emit_line;
    logic                      w_start;
    logic                      w_fetch;
    logic [DA_W-1:0]           w_rd_next;

    assign w_word        = dma.data;
    assign w_unused_bits = ^w_word;
    assign dma.ready     = (r_state == IDLE) || (r_state == LOAD) || (r_state == READY);
    assign w_accept      = dma.valid && dma.ready;
    assign w_wr_addr     = (r_state == LOAD) ? r_wr_cnt[SA_W-1:0] : '0;
    assign w_wr_en       = w_accept && ((r_state != LOAD) || (r_wr_cnt < SC_W'(SPARSE_BRAM_DEPTH)));

    // Stored word drops bit 0: [46:31] value, [30:15] slope, [14:0] dur.
    assign w_seg   = r_sparse[r_seg_idx[SA_W-1:0]];
    assign w_value = SAMPLE_WIDTH'(w_seg[46:31]);
    assign w_slope = SAMPLE_WIDTH'($signed(w_seg[30:15]));
    assign w_dur   = w_seg[14:0];

    assign w_sample        = (r_k == '0) ? w_value : r_acc + w_slope;
    assign w_finish        = (r_state == EXPAND) &&
                             ((r_seg_idx == r_wr_cnt) || (r_batch_cnt == DC_W'(DENSE_BRAM_DEPTH)));
    assign w_pad           = (r_fill != '0);
    assign w_final_batches = r_batch_cnt + DC_W'(w_pad);
    assign w_gen           = (r_state == EXPAND) && !w_finish && (w_dur != '0);
    assign w_emit_line     = w_gen && (r_fill == FILL_W'(BATCH_SIZE - 1));

    always_comb begin
        w_line_ins = r_line;
        w_line_pad = r_line;
        for (int i = 0; i < BATCH_SIZE; i++) begin
            if (i == int'(r_fill)) w_line_ins[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = w_sample;
            if (i >= int'(r_fill)) w_line_pad[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_acc;
        end
    end

    // A new load has priority over a run request arriving in the same READY cycle.
    assign w_start   = (r_state == READY) && run && !halt && !w_accept;
    assign w_fetch   = (r_state == RUN) && !halt && (!r_loaded || dac0_rdy);
    assign w_rd_next = (DC_W'(r_rd_addr) == r_num_batches - 1'b1) ? '0 : r_rd_addr + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = dma.last ? EXPAND : LOAD;
            LOAD:    if (w_accept && dma.last) w_next = EXPAND;
            EXPAND:  if (w_finish) w_next = (w_final_batches == '0) ? IDLE : READY;
            READY: begin
                if (w_accept)     w_next = dma.last ? EXPAND : LOAD;
                else if (w_start) w_next = RUN;
            end
            RUN:     if (halt) w_next = READY;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_sparse[w_wr_addr] <= w_word[47:1];
        if (w_emit_line)          r_dense[r_batch_cnt[DA_W-1:0]] <= w_line_ins;
        else if (w_finish && w_pad) r_dense[r_batch_cnt[DA_W-1:0]] <= w_line_pad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt      <= '0;
            r_seg_idx     <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_line        <= '0;
            r_fill        <= '0;
            r_batch_cnt   <= '0;
            r_num_batches <= '0;
            r_rd_addr     <= '0;
            r_batch_out   <= '0;
            r_loaded      <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_state == LOAD) begin
                    if (r_wr_cnt < SC_W'(SPARSE_BRAM_DEPTH)) r_wr_cnt <= r_wr_cnt + 1'b1;
                end else begin
                    r_wr_cnt      <= SC_W'(1);
                    r_num_batches <= '0;
                end
                r_seg_idx   <= '0;
                r_k         <= '0;
                r_fill      <= '0;
                r_batch_cnt <= '0;
            end

            if (w_finish) begin
                r_num_batches <= w_final_batches;
            end else if ((r_state == EXPAND) && (w_dur == '0)) begin
                r_seg_idx <= r_seg_idx + 1'b1;
            end else if (w_gen) begin
                r_acc  <= w_sample;
                r_line <= w_line_ins;
                r_fill <= w_emit_line ? '0 : r_fill + 1'b1;
                if (w_emit_line) r_batch_cnt <= r_batch_cnt + 1'b1;
                if (r_k == w_dur - 1'b1) begin
                    r_k       <= '0;
                    r_seg_idx <= r_seg_idx + 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end

            if (w_start) r_rd_addr <= '0;
            if ((r_state != RUN) || halt) begin
                r_loaded    <= 1'b0;
                r_batch_out <= '0;
            end else if (w_fetch) begin
                r_batch_out <= r_dense[r_rd_addr];
                r_loaded    <= 1'b1;
                r_rd_addr   <= w_rd_next;
            end
        end
    end

    assign rdy_to_run      = (r_state == READY);
    assign valid_batch_out = (r_state == RUN) && r_loaded && dac0_rdy;
    assign batch_out       = r_batch_out;

endmodule

// File: tb/tb_pwl_generator.sv
// Directed and randomized checks of pwl_generator against a sample-list reference model.
module tb_pwl_generator;
    localparam int SW = 16;
    localparam int BS = 16;
    localparam int SP = 8;
    localparam int DN = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          halt = 1'b0;
    logic          run = 1'b0;
    logic          dac0_rdy = 1'b0;
    logic          rdy_to_run;
    logic          valid_batch_out;
    logic [BS*SW-1:0] batch_out;

    Axis_IF #(.DATA_WIDTH(48)) dma_if ();

    pwl_generator #(
        .DMA_DATA_WIDTH(48), .SAMPLE_WIDTH(SW), .BATCH_SIZE(BS),
        .SPARSE_BRAM_DEPTH(SP), .DENSE_BRAM_DEPTH(DN)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt), .run(run), .rdy_to_run(rdy_to_run),
        .dac0_rdy(dac0_rdy), .batch_out(batch_out), .valid_batch_out(valid_batch_out),
        .dma(dma_if)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               idx     = 0;
    logic [47:0]      words[$];
    logic [BS*SW-1:0] exp_b[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mkword(input int v, input int s, input int d);
        return {16'(v), 16'(s), 15'(d), 1'b0};
    endfunction

    // Reference: list every sample value + k*slope, cap, cut into batches, pad with the last sample.
    function automatic void build_model();
        logic [SW-1:0]    smp[$];
        logic [BS*SW-1:0] line;
        smp = {};
        for (int w = 0; w < words.size() && w < SP; w++) begin
            int v = int'(words[w][47:32]);
            int s = int'($signed(words[w][31:16]));
            int d = int'(words[w][15:1]);
            for (int k = 0; k < d; k++) smp.push_back(SW'(v + k * s));
        end
        while (smp.size() > DN * BS) void'(smp.pop_back());
        exp_b = {};
        for (int b = 0; b * BS < smp.size(); b++) begin
            for (int i = 0; i < BS; i++) begin
                int j = b * BS + i;
                line[i*SW +: SW] = (j < smp.size()) ? smp[j] : smp[smp.size()-1];
            end
            exp_b.push_back(line);
        end
    endfunction

    task automatic send_all();
        for (int i = 0; i < words.size(); i++) begin
            int t = 0;
            dma_if.data  = words[i];
            dma_if.valid = 1'b1;
            dma_if.last  = (i == words.size() - 1);
            while (!dma_if.ready && t < 50) begin @(posedge clk); #1; t++; end
            check("dma_ready", dma_if.ready, 1'b1);
            @(posedge clk); #1;
            if (i == 0) check("rdy_cleared_on_load", rdy_to_run, 1'b0);
        end
        dma_if.valid = 1'b0;
        dma_if.last  = 1'b0;
        dma_if.data  = '0;
    endtask

    task automatic wait_expanded();
        int t = 0;
        while (!rdy_to_run && t < 1000) begin @(posedge clk); #1; t++; end
        check("rdy_to_run_after_expand", rdy_to_run, 1'b1);
    endtask

    task automatic load_and_wait();
        build_model();
        send_all();
        if (exp_b.size() > 0) wait_expanded();
        else begin
            repeat (40) @(posedge clk);
            #1;
            check("empty_rdy_low", rdy_to_run, 1'b0);
            check("empty_back_to_idle", dma_if.ready, 1'b1);
        end
    endtask

    task automatic start_run();
        @(posedge clk); #1; run = 1'b1; halt = 1'b0; dac0_rdy = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        @(negedge clk);
        check("run_latency_gap", valid_batch_out, 1'b0);
        check("rdy_low_in_run", rdy_to_run, 1'b0);
        idx = 0;
    endtask

    task automatic step(input logic d, input logic r);
        @(posedge clk); #1; dac0_rdy = d; run = r;
        @(negedge clk);
        if (d) begin
            check("batch_vld", valid_batch_out, 1'b1);
            check("batch_dat", batch_out, exp_b[idx]);
            idx = (idx + 1) % exp_b.size();
        end else begin
            check("batch_hold_vld", valid_batch_out, 1'b0);
        end
    endtask

    task automatic do_halt();
        @(posedge clk); #1; halt = 1'b1; run = 1'b0; dac0_rdy = 1'b1;
        @(posedge clk); #1; halt = 1'b0;
        @(negedge clk);
        check("halt_vld", valid_batch_out, 1'b0);
        check("halt_dat", batch_out, '0);
        check("halt_rdy", rdy_to_run, 1'b1);
    endtask

    initial begin
        dma_if.data = '0; dma_if.valid = 1'b0; dma_if.last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", rdy_to_run, 1'b0);
        check("rst_vld", valid_batch_out, 1'b0);
        check("rst_dat", batch_out, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dma_ready", dma_if.ready, 1'b1);

        // Six-segment reference waveform: 192 samples, 12 batches.
        words = {48'd131169, 48'd412316991508, 48'd498216271884,
                 48'd528280912097, 48'd47244509194, 48'd22};
        load_and_wait();
        start_run();
        for (int i = 0; i < 26; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        do_halt();

        @(posedge clk); #1; halt = 1'b1;
        @(negedge clk);
        check("halt_ignored_in_ready", rdy_to_run, 1'b1);
        @(posedge clk); #1; halt = 1'b1; run = 1'b1;
        @(posedge clk); #1; halt = 1'b0; run = 1'b0;
        @(negedge clk);
        check("halt_beats_run_rdy", rdy_to_run, 1'b1);
        check("halt_beats_run_vld", valid_batch_out, 1'b0);

        start_run();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(($urandom_range(0, 3) != 0), 1'b0);
        do_halt();

        words = {mkword(5, 0, 3)};
        load_and_wait();
        start_run();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        do_halt();

        words = {mkword(7, 3, 0)};
        load_and_wait();
        @(posedge clk); #1; run = 1'b1; dac0_rdy = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("empty_no_play", valid_batch_out, 1'b0);

        for (int it = 0; it < 5; it++) begin
            int n = (it == 0) ? 10 : int'($urandom_range(1, 10));
            words = {};
            for (int w = 0; w < n; w++)
                words.push_back(mkword(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                                       ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40))));
            load_and_wait();
            if (exp_b.size() > 0) begin
                start_run();
                for (int i = 0; i < 30; i++) step(($urandom_range(0, 3) != 0), 1'b0);
                do_halt();
            end
        end

        words = {mkword(5, 0, 3)};
        load_and_wait();
        start_run();
        step(1'b1, 1'b0);
        @(posedge clk); #1; rst = 1'b1; #1;
        check("rst_run_vld", valid_batch_out, 1'b0);
        check("rst_run_dat", batch_out, '0);
        check("rst_run_rdy", rdy_to_run, 1'b0);
        @(posedge clk); #1; rst = 1'b0;

        words = {48'd131169, 48'd412316991508, 48'd498216271884,
                 48'd528280912097, 48'd47244509194, 48'd22};
        build_model();
        send_all();
        repeat (20) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("rst_exp_vld", valid_batch_out, 1'b0);
        check("rst_exp_dat", batch_out, '0);
        check("rst_exp_rdy", rdy_to_run, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("rst_exp_stays_unready", rdy_to_run, 1'b0);
        run = 1'b1; dac0_rdy = 1'b1;
        @(posedge clk); #1; run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_exp_no_play", valid_batch_out, 1'b0);

        load_and_wait();
        start_run();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        do_halt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
